// File: rtl/zpu_sd_sector_ctrl_pkg.sv
// Shared types and constants for the ZPU SD sector controller:
// FSM encoding, status-word bit positions and sector-buffer geometry.
package atari_sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } sd_state_t;

  localparam int SECTOR_BYTES = 512;
  localparam int BUF_AW       = $clog2(SECTOR_BYTES);

  localparam int STATUS_DONE         = 0;
  localparam int STATUS_MOUNTED      = 1;
  localparam int STATUS_FILENO_LSB   = 2;
  localparam int STATUS_FILETYPE_LSB = 5;
  localparam int STATUS_READONLY     = 7;

  function automatic logic [7:0] pack_status(input logic       done,
                                             input logic       mounted,
                                             input logic [2:0] fileno,
                                             input logic [1:0] filetype,
                                             input logic       readonly);
    logic [7:0] s;
    s = '0;
    s[STATUS_DONE]                    = done;
    s[STATUS_MOUNTED]                 = mounted;
    s[STATUS_FILENO_LSB +: 3]         = fileno;
    s[STATUS_FILETYPE_LSB +: 2]       = filetype;
    s[STATUS_READONLY]                = readonly;
    return s;
  endfunction

endpackage

// File: rtl/zpu_sd_sector_ctrl_if.sv
// Sector request channel between the sector controller (master) and hps_io (slave).
interface zpu_sd_sector_ctrl_if;
  // Handshake: the master raises sd_rd or sd_wr (never both) with sd_lba stable and
  // holds it until sd_ack is seen high; the slave keeps sd_ack high for the whole
  // 512-byte transfer and its falling edge marks completion.
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/zpu_sd_sector_ctrl_edge_det.sv
// Edge detector over a registered copy of a level; DELAY > 1 moves the detected
// edge DELAY-1 cycles later through extra history flops.
module edge_det #(
  parameter int DELAY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [DELAY-1:0] sh;
  logic [DELAY:0]   tap;

  assign tap = {sh, d};

  // Preloading with the live level keeps a signal held across reset from
  // looking like a fresh edge once reset drops.
  always_ff @(posedge clk) begin
    if (reset) sh <= {DELAY{d}};
    else       sh <= tap[DELAY-1:0];
  end

  assign rise =  tap[DELAY-1] & ~tap[DELAY];
  assign fall = ~tap[DELAY-1] &  tap[DELAY];

endmodule

// File: rtl/zpu_sd_sector_ctrl.sv
// Sequences 512-byte sector transfers between the ZPU firmware registers and
// hps_io, owns dpram port B and publishes the done/error/mount status word.
module zpu_sd_sector_ctrl
  import atari_sd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 cmd_lba_sel,
  input  logic                 cmd_rd,
  input  logic                 cmd_wr,
  input  logic                 zpu_io_wr,
  input  logic                 zpu_data_wr,
  input  logic                 zpu_data_rd,
  input  logic [31:0]          zpu_wdata,
  output logic [31:0]          zpu_rdata,
  output logic [7:0]           zpu_status,
  output logic                 io_err,
  output logic [BUF_AW-1:0]    buf_addr,
  output logic                 buf_wr,
  output logic [7:0]           buf_wdata,
  input  logic [7:0]           buf_q,
  zpu_sd_sector_ctrl_if.master sd,
  input  logic                 img_mounted,
  input  logic [63:0]          img_size,
  input  logic [7:0]           ioctl_index,
  output sd_state_t            dbg_state
);

  localparam logic [23:0] TMO_LAST = TIMEOUT_CYCLES - 24'd1;

  logic rd_rise, wr_rise, drd_fall, dwr_rise, mnt_rise, ack_fall;
  logic rd_fall_unused, wr_fall_unused, drd_rise_unused, dwr_fall_unused;
  logic mnt_fall_unused, ack_rise_unused, unused_inputs;

  sd_state_t   state;
  logic [23:0] tmo_cnt;
  logic        io_done, mounted, readonly;
  logic [2:0]  fileno;
  logic [1:0]  filetype;
  logic [31:0] filesize;

  edge_det #(.DELAY(1)) u_rd  (.clk(clk_sys), .reset(reset), .d(cmd_rd),      .rise(rd_rise),         .fall(rd_fall_unused));
  edge_det #(.DELAY(1)) u_wr  (.clk(clk_sys), .reset(reset), .d(cmd_wr),      .rise(wr_rise),         .fall(wr_fall_unused));
  edge_det #(.DELAY(1)) u_drd (.clk(clk_sys), .reset(reset), .d(zpu_data_rd), .rise(drd_rise_unused), .fall(drd_fall));
  edge_det #(.DELAY(2)) u_dwr (.clk(clk_sys), .reset(reset), .d(zpu_data_wr), .rise(dwr_rise),        .fall(dwr_fall_unused));
  edge_det #(.DELAY(1)) u_mnt (.clk(clk_sys), .reset(reset), .d(img_mounted), .rise(mnt_rise),        .fall(mnt_fall_unused));
  edge_det #(.DELAY(1)) u_ack (.clk(clk_sys), .reset(reset), .d(sd.sd_ack),   .rise(ack_rise_unused), .fall(ack_fall));

  assign unused_inputs = ^{img_size[63:32], ioctl_index[5:0]};

  // Buffer address and LBA register; a rewind wins over any pending increment.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      buf_wr    <= 1'b0;
      buf_addr  <= '0;
      sd.sd_lba <= '0;
    end else begin
      buf_wr <= dwr_rise & ~cmd_lba_sel;
      if (dwr_rise && cmd_lba_sel) sd.sd_lba <= zpu_wdata;
      if (zpu_io_wr)               buf_addr <= '0;
      else if (buf_wr || drd_fall) buf_addr <= buf_addr + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ST_IDLE;
      sd.sd_rd <= 1'b0;
      sd.sd_wr <= 1'b0;
      io_done  <= 1'b1;
      io_err   <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // Read has priority; a simultaneous write edge is simply lost.
          if (rd_rise || wr_rise) begin
            sd.sd_rd <= rd_rise;
            sd.sd_wr <= ~rd_rise;
            io_done  <= 1'b0;
            io_err   <= 1'b0;
            tmo_cnt  <= '0;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sd.sd_ack) begin
            sd.sd_rd <= 1'b0;
            sd.sd_wr <= 1'b0;
            state    <= ST_XFER;
          end else if (TIMEOUT_CYCLES != 24'd0 && tmo_cnt == TMO_LAST) begin
            sd.sd_rd <= 1'b0;
            sd.sd_wr <= 1'b0;
            io_err   <= 1'b1;
            io_done  <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        ST_XFER: begin
          if (ack_fall) begin
            io_done <= 1'b1;
            state   <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Mount metadata follows hps_io regardless of any transfer in flight.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fileno   <= 3'd0;
      filetype <= 2'd0;
      readonly <= 1'b1;
      mounted  <= |img_size[31:0];
      filesize <= img_size[31:0];
    end else if (mnt_rise) begin
      fileno   <= 3'd0;
      filetype <= ioctl_index[7:6];
      readonly <= 1'b1;
      mounted  <= ~mounted;
      filesize <= img_size[31:0];
    end
  end

  assign zpu_rdata  = cmd_lba_sel ? filesize : {24'b0, buf_q};
  assign zpu_status = pack_status(io_done, mounted, fileno, filetype, readonly);
  assign buf_wdata  = zpu_wdata[7:0];
  assign dbg_state  = state;

endmodule

// File: tb/tb_zpu_sd_sector_ctrl.sv
// Randomized bench for zpu_sd_sector_ctrl: each scenario task drives stimulus and
// checks outputs against expectations derived from the cycle rules of the block.
module tb_zpu_sd_sector_ctrl;
  import atari_sd_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_lba_sel = 1'b0, cmd_rd = 1'b0, cmd_wr = 1'b0;
  logic        zpu_io_wr = 1'b0, zpu_data_wr = 1'b0, zpu_data_rd = 1'b0;
  logic [31:0] zpu_wdata = '0;
  logic [31:0] zpu_rdata;
  logic [7:0]  zpu_status;
  logic        io_err;
  logic [8:0]  buf_addr;
  logic        buf_wr;
  logic [7:0]  buf_wdata;
  logic [7:0]  buf_q = '0;
  logic        img_mounted = 1'b0;
  logic [63:0] img_size = '0;
  logic [7:0]  ioctl_index = '0;
  sd_state_t   dbg_state;

  zpu_sd_sector_ctrl_if sd_if ();

  zpu_sd_sector_ctrl #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk_sys(clk_sys), .reset(reset), .cmd_lba_sel(cmd_lba_sel), .cmd_rd(cmd_rd),
    .cmd_wr(cmd_wr), .zpu_io_wr(zpu_io_wr), .zpu_data_wr(zpu_data_wr),
    .zpu_data_rd(zpu_data_rd), .zpu_wdata(zpu_wdata), .zpu_rdata(zpu_rdata),
    .zpu_status(zpu_status), .io_err(io_err), .buf_addr(buf_addr), .buf_wr(buf_wr),
    .buf_wdata(buf_wdata), .buf_q(buf_q), .sd(sd_if), .img_mounted(img_mounted),
    .img_size(img_size), .ioctl_index(ioctl_index), .dbg_state(dbg_state)
  );

  // Clock / reference state
  always #5 clk_sys = ~clk_sys;

  int          tests = 0;
  int          failed = 0;
  logic        mounted_m;
  logic [1:0]  filetype_m;
  logic [31:0] filesize_m;
  logic [31:0] lba_m;
  logic [8:0]  addr_m;
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];

  // Port-B write observer, sampled mid-cycle.
  always @(negedge clk_sys) if (buf_wr === 1'b1) obs_q.push_back({buf_addr, buf_wdata});

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    img_size = {$urandom, $urandom};
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    mounted_m = |img_size[31:0];
    filetype_m = 2'd0;
    lba_m = '0;
    addr_m = '0;
    tests++;
    if ({sd_if.sd_rd, sd_if.sd_wr, buf_wr, io_err, buf_addr, sd_if.sd_lba} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got rd=%b wr=%b bwr=%b err=%b addr=%0d lba=%h, want all 0",
               sd_if.sd_rd, sd_if.sd_wr, buf_wr, io_err, buf_addr, sd_if.sd_lba);
    end
    tests++;
    if (zpu_status !== {1'b1, filetype_m, 3'b000, mounted_m, 1'b1}) begin
      failed++;
      $display("FAIL reset_status: got %b want %b", zpu_status, {1'b1, filetype_m, 3'b000, mounted_m, 1'b1});
    end
    tests++;
    if (dbg_state !== ST_IDLE) begin
      failed++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_lba_write();
    logic [31:0] v;
    for (int it = 0; it < 4; it++) begin
      v = (it == 0) ? 32'h0000_1234 : $urandom;
      cmd_lba_sel = 1'b1;
      zpu_wdata = v;
      zpu_data_wr = 1'b1;
      for (int c = 1; c <= 6; c++) begin
        step();
        tests++;
        if (buf_wr !== 1'b0) begin
          failed++;
          $display("FAIL lba_no_buf_wr: cycle %0d got %b want 0", c, buf_wr);
        end
        if (c == 1) begin
          tests++;
          if (sd_if.sd_lba !== lba_m) begin
            failed++;
            $display("FAIL lba_early: got %h want %h", sd_if.sd_lba, lba_m);
          end
        end
        if (c == 2) begin
          tests++;
          if (sd_if.sd_lba !== v) begin
            failed++;
            $display("FAIL lba_load: got %h want %h", sd_if.sd_lba, v);
          end
        end
        if (c == 4) zpu_data_wr = 1'b0;
      end
      lba_m = v;
      tests++;
      if (buf_addr !== addr_m) begin
        failed++;
        $display("FAIL lba_addr_kept: got %0d want %0d", buf_addr, addr_m);
      end
    end
  endtask

  task automatic test_buffer_fill();
    logic [7:0]  b;
    logic [16:0] o;
    int          h, l, n;
    cmd_lba_sel = 1'b0;
    n = $urandom_range(3, 9);
    for (int i = 0; i < n; i++) begin
      buf_q = 8'($urandom);
      zpu_data_rd = 1'b1;
      step();
      tests++;
      if (zpu_rdata !== {24'b0, buf_q}) begin
        failed++;
        $display("FAIL rdata_buf: got %h want %h", zpu_rdata, {24'b0, buf_q});
      end
      zpu_data_rd = 1'b0;
      step();
      addr_m = addr_m + 9'd1;
      tests++;
      if (buf_addr !== addr_m) begin
        failed++;
        $display("FAIL read_inc: got %0d want %0d", buf_addr, addr_m);
      end
    end
    // Rewind coinciding with a read-strobe fall.
    zpu_data_rd = 1'b1;
    step();
    zpu_data_rd = 1'b0;
    zpu_io_wr = 1'b1;
    step();
    zpu_io_wr = 1'b0;
    addr_m = '0;
    tests++;
    if (buf_addr !== 9'd0) begin
      failed++;
      $display("FAIL rewind_override: got %0d want 0", buf_addr);
    end
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < 512; i++) begin
      b = 8'($urandom);
      zpu_wdata = {24'($urandom), b};
      exp_q.push_back({9'(i), b});
      h = $urandom_range(1, 3);
      l = ((h >= 2) ? 1 : 2) + $urandom_range(0, 1);
      zpu_data_wr = 1'b1;
      repeat (h) step();
      zpu_data_wr = 1'b0;
      repeat (l) step();
    end
    repeat (3) step();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL fill_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      o = (k < obs_q.size()) ? obs_q[k] : 17'h1ffff;
      tests++;
      if (o !== exp_q[k]) begin
        failed++;
        $display("FAIL fill_write[%0d]: got addr %0d data %h want addr %0d data %h",
                 k, o[16:8], o[7:0], exp_q[k][16:8], exp_q[k][7:0]);
      end
    end
    tests++;
    if (buf_addr !== 9'd0) begin
      failed++;
      $display("FAIL fill_wrap: got %0d want 0", buf_addr);
    end
  endtask

  task automatic test_sector_xfer(input bit is_wr, input int dly, input int width);
    logic exp_req, exp_done, req, other;
    if (is_wr) cmd_wr = 1'b1;
    else       cmd_rd = 1'b1;
    for (int c = 1; c <= dly + width + 1; c++) begin
      step();
      exp_req  = (c <= dly);
      exp_done = (c > dly + width);
      req   = is_wr ? sd_if.sd_wr : sd_if.sd_rd;
      other = is_wr ? sd_if.sd_rd : sd_if.sd_wr;
      tests++;
      if (req !== exp_req) begin
        failed++;
        $display("FAIL xfer_req: wr=%0d cycle %0d got %b want %b", is_wr, c, req, exp_req);
      end
      tests++;
      if (other !== 1'b0) begin
        failed++;
        $display("FAIL xfer_other_req: wr=%0d cycle %0d got %b want 0", is_wr, c, other);
      end
      tests++;
      if (zpu_status[0] !== exp_done) begin
        failed++;
        $display("FAIL xfer_done: wr=%0d cycle %0d got %b want %b", is_wr, c, zpu_status[0], exp_done);
      end
      if (c == 2) begin
        cmd_rd = 1'b0;
        cmd_wr = 1'b0;
      end
      if (c == dly)         sd_if.sd_ack = 1'b1;
      if (c == dly + width) sd_if.sd_ack = 1'b0;
    end
    tests++;
    if (dbg_state !== ST_DONE || io_err !== 1'b0) begin
      failed++;
      $display("FAIL xfer_end: got state %0d err %b want state %0d err 0", dbg_state, io_err, ST_DONE);
    end
  endtask

  task automatic test_conflict();
    cmd_rd = 1'b1;
    cmd_wr = 1'b1;
    step();
    tests++;
    if ({sd_if.sd_rd, sd_if.sd_wr} !== 2'b10) begin
      failed++;
      $display("FAIL conflict_read_wins: got rd=%b wr=%b want rd=1 wr=0", sd_if.sd_rd, sd_if.sd_wr);
    end
    step();
    cmd_rd = 1'b0;
    step();
    sd_if.sd_ack = 1'b1;
    step();
    tests++;
    if (dbg_state !== ST_XFER) begin
      failed++;
      $display("FAIL conflict_xfer: got state %0d want %0d", dbg_state, ST_XFER);
    end
    cmd_rd = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) sd_if.sd_ack = 1'b0;
      step();
      tests++;
      if ({sd_if.sd_rd, sd_if.sd_wr} !== 2'b00) begin
        failed++;
        $display("FAIL conflict_no_queue: cycle %0d got rd=%b wr=%b want 0 0", c, sd_if.sd_rd, sd_if.sd_wr);
      end
      if (c == 3) begin
        tests++;
        if (zpu_status[0] !== 1'b1) begin
          failed++;
          $display("FAIL conflict_done: got %b want 1", zpu_status[0]);
        end
      end
    end
    cmd_rd = 1'b0;
    cmd_wr = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    cmd_rd = 1'b1;
    for (int c = 1; c <= 101; c++) begin
      step();
      if (c == 2) cmd_rd = 1'b0;
      tests++;
      if (sd_if.sd_rd !== (c <= 100)) begin
        failed++;
        $display("FAIL timeout_req: cycle %0d got %b want %b", c, sd_if.sd_rd, (c <= 100));
      end
      tests++;
      if ({io_err, zpu_status[0]} !== ((c <= 100) ? 2'b00 : 2'b11)) begin
        failed++;
        $display("FAIL timeout_flags: cycle %0d got err=%b done=%b", c, io_err, zpu_status[0]);
      end
    end
    repeat (5) step();
    tests++;
    if (io_err !== 1'b1 || dbg_state !== ST_IDLE) begin
      failed++;
      $display("FAIL timeout_sticky: got err=%b state %0d want err=1 state %0d", io_err, dbg_state, ST_IDLE);
    end
    cmd_wr = 1'b1;
    step();
    tests++;
    if ({sd_if.sd_wr, io_err} !== 2'b10) begin
      failed++;
      $display("FAIL timeout_clear: got wr=%b err=%b want wr=1 err=0", sd_if.sd_wr, io_err);
    end
    cmd_wr = 1'b0;
    sd_if.sd_ack = 1'b1;
    step();
    sd_if.sd_ack = 1'b0;
    step();
    tests++;
    if (zpu_status[0] !== 1'b1) begin
      failed++;
      $display("FAIL timeout_recover: got done=%b want 1", zpu_status[0]);
    end
  endtask

  task automatic test_mount();
    for (int it = 0; it < 5; it++) begin
      if (it == 4) begin
        cmd_rd = 1'b1;
        step();
        cmd_rd = 1'b0;
      end
      img_size = {$urandom, $urandom};
      ioctl_index = 8'($urandom);
      img_mounted = 1'b1;
      step();
      img_mounted = 1'b0;
      mounted_m = ~mounted_m;
      filetype_m = ioctl_index[7:6];
      filesize_m = img_size[31:0];
      tests++;
      if (zpu_status !== {1'b1, filetype_m, 3'b000, mounted_m, (it != 4)}) begin
        failed++;
        $display("FAIL mount_status: it %0d got %b want %b", it, zpu_status, {1'b1, filetype_m, 3'b000, mounted_m, (it != 4)});
      end
      cmd_lba_sel = 1'b1;
      #1;
      tests++;
      if (zpu_rdata !== filesize_m) begin
        failed++;
        $display("FAIL mount_filesize: got %h want %h", zpu_rdata, filesize_m);
      end
      cmd_lba_sel = 1'b0;
      step();
    end
    tests++;
    if (sd_if.sd_rd !== 1'b1) begin
      failed++;
      $display("FAIL mount_keeps_req: got %b want 1", sd_if.sd_rd);
    end
    sd_if.sd_ack = 1'b1;
    step();
    sd_if.sd_ack = 1'b0;
    step();
    tests++;
    if (zpu_status[0] !== 1'b1) begin
      failed++;
      $display("FAIL mount_xfer_done: got %b want 1", zpu_status[0]);
    end
  endtask

  task automatic test_reset_mid_transfer();
    cmd_rd = 1'b1;
    step();
    cmd_rd = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (sd_if.sd_rd !== 1'b0) begin
      failed++;
      $display("FAIL reset_req_drop: got %b want 0", sd_if.sd_rd);
    end
    img_size = {$urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'd0};
    cmd_wr = 1'b1;
    step();
    cmd_wr = 1'b0;
    sd_if.sd_ack = 1'b1;
    step();
    tests++;
    if (dbg_state !== ST_XFER) begin
      failed++;
      $display("FAIL reset_xfer_entry: got %0d want %0d", dbg_state, ST_XFER);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    mounted_m = |img_size[31:0];
    filetype_m = 2'd0;
    tests++;
    if ({sd_if.sd_wr, sd_if.sd_lba} !== '0 || zpu_status !== {1'b1, 2'b00, 3'b000, mounted_m, 1'b1}) begin
      failed++;
      $display("FAIL reset_in_xfer: got wr=%b lba=%h status=%b want 0 0 %b",
               sd_if.sd_wr, sd_if.sd_lba, zpu_status, {1'b1, 2'b00, 3'b000, mounted_m, 1'b1});
    end
    repeat (4) step();
    sd_if.sd_ack = 1'b0;
    repeat (3) step();
    tests++;
    if (dbg_state !== ST_IDLE || zpu_status[0] !== 1'b1 || {sd_if.sd_rd, sd_if.sd_wr} !== 2'b00) begin
      failed++;
      $display("FAIL stray_ack_fall: got state %0d done=%b rd=%b wr=%b want state %0d done=1 rd=0 wr=0",
               dbg_state, zpu_status[0], sd_if.sd_rd, sd_if.sd_wr, ST_IDLE);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    sd_if.sd_ack = 1'b0;
    test_reset();
    test_lba_write();
    test_buffer_fill();
    test_sector_xfer(1'b0, 10, 600);
    for (int i = 0; i < 6; i++)
      test_sector_xfer(1'($urandom_range(0, 1)), $urandom_range(1, 40), $urandom_range(1, 50));
    test_conflict();
    test_timeout();
    test_mount();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
